// File: rtl/fp_pkg.sv
// Shared single-precision add/subtract definitions: field widths, bias,
// sequencer state encoding, unpacked operand type and special constants.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 28;   // [27] carry, [26] hidden, [25:3] fraction, [2:0] g/r/s
    localparam int BIAS   = 127;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } fp_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_unpacked_t;

    // Unpack an IEEE single into the internal mantissa layout. Denormals
    // (exp = 0) are flushed to a signed zero. 'flip' inverts the sign.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] v, input logic flip);
        fp_unpacked_t u;
        u.sign = v[31] ^ flip;
        u.exp  = v[30:FRAC_W];
        if (v[30:FRAC_W] == '0)
            u.mant = '0;
        else
            u.mant = {1'b0, 1'b1, v[FRAC_W-1:0], 3'b000};
        return u;
    endfunction

endpackage

// File: rtl/fp_add_sequencer_align_shift.sv
// fp_align_shift: combinational right shifter with sticky collection.
// Bits shifted out of the bottom are ORed into bit 0. A shift of W-1 or more
// leaves only the sticky bit, set when the input was non-zero.
module fp_align_shift #(
    parameter int W    = 28,
    parameter int SH_W = 8
) (
    input  logic [W-1:0]    din,
    input  logic [SH_W-1:0] shamt,
    output logic [W-1:0]    dout
);

    logic [W-1:0] lost_mask;
    logic [W-1:0] shifted;

    // Mark every bit position that falls off the bottom for this shift amount.
    for (genvar i = 0; i < W; i++) begin : g_mask
        assign lost_mask[i] = ({{(32-SH_W){1'b0}}, shamt} > 32'(i));
    end

    // Shift and fold the lost bits into the sticky position.
    always_comb begin
        shifted = din >> shamt;
        dout    = '0;
        if (shamt >= SH_W'(W-1))
            dout[0] = |din;
        else
            dout = {shifted[W-1:1], shifted[0] | (|(din & lost_mask))};
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: multi-cycle IEEE-754 single add/subtract.
// IDLE -> ALIGN -> ADD -> NORM (k extra cycles for left shifts) -> ROUND -> DONE.
// Optional macro FP_ADD_SPECIALS_EN: detects NaN/inf at capture and bypasses
// ALIGN straight to DONE; without it exp=255 is an ordinary exponent and the
// invalid flag is tied low.
module fp_add_sequencer #(
    parameter int MANT_W = fp_pkg::MANT_W,
    parameter int EXP_W  = fp_pkg::EXP_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        op_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  flags,
    output logic        busy
);
    import fp_pkg::*;

    // Exponent is carried one bit wider so that overflow past 254 is visible.
    localparam logic [EXP_W:0] EXP_INF = (EXP_W+1)'(2*BIAS+1);
    localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);

    fp_state_t         state;
    fp_unpacked_t      opa, opb;
    logic              sign_q;
    logic              eff_sub_q;
    logic              flush_q;
    logic [EXP_W:0]    exp_q;
    logic [MANT_W-1:0] mant_q;
    logic [MANT_W-1:0] sml_q;
    logic [31:0]       result_q;
    logic [1:0]        flags_q;      // {overflow, inexact}
    logic              inv_bit;
    logic              out_valid_q, in_ready_q, busy_q;

    // ---------------- ALIGN: order operands and align the small one -------
    logic              a_ge, mag_eq;
    logic              grt_sign;
    logic [EXP_W-1:0]  grt_exp, sml_exp, exp_diff;
    logic [MANT_W-1:0] grt_mant, sml_mant, sml_aligned;

    assign a_ge     = {opa.exp, opa.mant} >= {opb.exp, opb.mant};
    assign mag_eq   = {opa.exp, opa.mant} == {opb.exp, opb.mant};
    assign grt_sign = a_ge ? opa.sign : opb.sign;
    assign grt_exp  = a_ge ? opa.exp  : opb.exp;
    assign grt_mant = a_ge ? opa.mant : opb.mant;
    assign sml_exp  = a_ge ? opb.exp  : opa.exp;
    assign sml_mant = a_ge ? opb.mant : opa.mant;
    assign exp_diff = grt_exp - sml_exp;

    fp_align_shift #(.W(MANT_W), .SH_W(EXP_W)) u_align (
        .din   (sml_mant),
        .shamt (exp_diff),
        .dout  (sml_aligned)
    );

    // ---------------- ROUND: nearest-even on guard/round/sticky -----------
    logic                rnd_up, inexact;
    logic [MANT_W-3-1:0] rnd_sum;    // carry + hidden + fraction
    logic [EXP_W:0]      rnd_exp;

    assign inexact = |mant_q[2:0];
    assign rnd_up  = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    assign rnd_sum = {1'b0, mant_q[MANT_W-2:3]} + (MANT_W-3)'(rnd_up);
    // A rounding carry leaves an all-zero fraction, so only the exponent moves.
    assign rnd_exp = exp_q + {{EXP_W{1'b0}}, rnd_sum[MANT_W-4]};

`ifdef FP_ADD_SPECIALS_EN
    // ---------------- Specials detection on the raw inputs -----------------
    logic        a_max, b_max, a_nan, b_nan, a_inf, b_inf, b_sgn;
    logic        sp_hit, sp_inv;
    logic [31:0] sp_res;
    logic        sp_hit_q, sp_inv_q;
    logic [31:0] sp_res_q;

    assign a_max = (op_a[30:FRAC_W] == '1);
    assign b_max = (op_b[30:FRAC_W] == '1);
    assign a_nan = a_max & (|op_a[FRAC_W-1:0]);
    assign b_nan = b_max & (|op_b[FRAC_W-1:0]);
    assign a_inf = a_max & ~(|op_a[FRAC_W-1:0]);
    assign b_inf = b_max & ~(|op_b[FRAC_W-1:0]);
    assign b_sgn = op_b[31] ^ op_sub;

    // Classify the operand pair: NaN in, inf - inf, or a single infinity.
    always_comb begin
        sp_hit = 1'b1;
        sp_inv = 1'b0;
        sp_res = '0;
        if (a_nan | b_nan) begin
            sp_res = FP_QNAN;
            sp_inv = 1'b1;
        end else if (a_inf & b_inf) begin
            if (op_a[31] != b_sgn) begin
                sp_res = FP_QNAN;
                sp_inv = 1'b1;
            end else begin
                sp_res = {op_a[31], FP_PINF[30:0]};
            end
        end else if (a_inf) begin
            sp_res = {op_a[31], FP_PINF[30:0]};
        end else if (b_inf) begin
            sp_res = {b_sgn, FP_PINF[30:0]};
        end else begin
            sp_hit = 1'b0;
        end
    end

    assign inv_bit = sp_inv_q;
`else
    assign inv_bit = 1'b0;
`endif

    // Sequencer FSM with registered handshake outputs and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            opa         <= '0;
            opb         <= '0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            flush_q     <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            sml_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
`ifdef FP_ADD_SPECIALS_EN
            sp_hit_q    <= 1'b0;
            sp_inv_q    <= 1'b0;
            sp_res_q    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        opa        <= fp_unpack(op_a, 1'b0);
                        opb        <= fp_unpack(op_b, op_sub);
`ifdef FP_ADD_SPECIALS_EN
                        sp_hit_q   <= sp_hit;
                        sp_inv_q   <= sp_inv;
                        sp_res_q   <= sp_res;
`endif
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
`ifdef FP_ADD_SPECIALS_EN
                    if (sp_hit_q) begin
                        result_q    <= sp_res_q;
                        flags_q     <= 2'b00;
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end else begin
`else
                    begin
`endif
                        // Exact cancellation of opposite signs yields +0.
                        sign_q    <= (mag_eq && (opa.sign != opb.sign)) ? 1'b0 : grt_sign;
                        eff_sub_q <= opa.sign ^ opb.sign;
                        exp_q     <= {1'b0, grt_exp};
                        mant_q    <= grt_mant;
                        sml_q     <= sml_aligned;
                        state     <= S_ADD;
                    end
                end
                S_ADD: begin
                    mant_q <= eff_sub_q ? (mant_q - sml_q) : (mant_q + sml_q);
                    state  <= S_NORM;
                end
                S_NORM: begin
                    if (mant_q[MANT_W-1]) begin
                        mant_q <= {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
                        exp_q  <= exp_q + EXP_ONE;
                        state  <= S_ROUND;
                    end else if (mant_q == '0) begin
                        sign_q <= 1'b0;
                        exp_q  <= '0;
                        state  <= S_ROUND;
                    end else if (mant_q[MANT_W-2]) begin
                        state  <= S_ROUND;
                    end else if (exp_q > EXP_ONE) begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - EXP_ONE;
                    end else begin
                        // Would go subnormal: flush to a signed zero.
                        flush_q <= 1'b1;
                        state   <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (flush_q) begin
                        result_q <= {sign_q, 31'b0};
                        flags_q  <= 2'b01;
                    end else if (rnd_exp >= EXP_INF) begin
                        result_q <= {sign_q, FP_PINF[30:0]};
                        flags_q  <= 2'b11;
                    end else begin
                        result_q <= {sign_q, rnd_exp[EXP_W-1:0], rnd_sum[FRAC_W-1:0]};
                        flags_q  <= {1'b0, inexact};
                    end
                    out_valid_q <= 1'b1;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        flush_q     <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign flags     = {flags_q, inv_bit};

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Scoreboard bench for fp_add_sequencer: directed vectors push expected
// result/flags/latency; a negedge monitor pops and compares on each output
// handshake, checks latency on the rising edge of out_valid and checks that
// outputs hold while stalled.
module tb_fp_add_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        op_sub = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] result;
    logic [2:0]  flags;

    fp_add_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
        int          hs;
        int          id;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s (vec %0d): got %h expected %h", nm, id, act, req);
        end
    endtask

    // Monitor: latency on first valid cycle, hold while stalled, compare on accept.
    logic        prev_v = 1'b0;
    logic [31:0] prev_res = '0;
    logic [2:0]  prev_flg = '0;
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                if (!prev_v) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_output: result %h flags %b with nothing outstanding", result, flags);
                end
            end else begin
                if (!prev_v)
                    chk("latency", exp_q[0].id, 32'(cyc - exp_q[0].hs + 1), 32'(exp_q[0].lat));
                else begin
                    chk("stall_hold_result", exp_q[0].id, result, prev_res);
                    chk("stall_hold_flags", exp_q[0].id, 32'(flags), 32'(prev_flg));
                end
                if (out_ready) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", e.id, result, e.res);
                    chk("flags", e.id, 32'(flags), 32'(e.flg));
                end
            end
        end
        prev_v   = out_valid;
        prev_res = result;
        prev_flg = flags;
    end

    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] er, input logic [2:0] ef, input int lat);
        exp_t e;
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout (vec %0d): in_ready stayed %b", id, in_ready);
            return;
        end
        op_a = a; op_b = b; op_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_sub   = 1'b0;
        e.res = er; e.flg = ef; e.lat = lat; e.hs = cyc; e.id = id;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0 || busy) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding, busy %b", exp_q.size(), busy);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 0, 32'(in_ready), 32'd1);
        chk("reset_out_valid", 0, 32'(out_valid), 32'd0);
        chk("reset_busy", 0, 32'(busy), 32'd0);
        chk("reset_result", 0, result, 32'h0);
        chk("reset_flags", 0, 32'(flags), 32'd0);
        rst_n = 1'b1;

        issue(1,  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 5);
        issue(2,  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 5);
        issue(3,  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b010, 5);
        issue(4,  32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000, 28);
        // While busy, the front end must ignore a competing request.
        chk("busy_mid_op", 4, 32'(busy), 32'd1);
        chk("in_ready_mid_op", 4, 32'(in_ready), 32'd0);
        op_a = 32'h40400000; op_b = 32'h40400000; in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        issue(5,  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b110, 5);
        issue(6,  32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 3'b000, 5);
        issue(7,  32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b010, 5);
        issue(8,  32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000, 5);
        issue(9,  32'hC0000000, 32'hBF800000, 1'b0, 32'hC0400000, 3'b000, 5);
        issue(10, 32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 3'b000, 5);
        issue(11, 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b010, 5);
`ifdef FP_ADD_SPECIALS_EN
        issue(12, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001, 2);
        issue(13, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000, 2);
        issue(14, 32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001, 2);
`endif
        drain();

        // Stall in DONE for 10 cycles; the monitor checks outputs hold.
        out_ready = 1'b0;
        issue(20, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 5);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            checks++;
            failures++;
            $display("FAIL stall_wait: out_valid %b after %0d cycles", out_valid, n);
        end
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Abort a long operation mid-normalise with reset.
        issue(21, 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000, 28);
        repeat (8) @(posedge clk);
        #1;
        chk("busy_before_abort", 21, 32'(busy), 32'd1);
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        chk("abort_out_valid", 21, 32'(out_valid), 32'd0);
        chk("abort_in_ready", 21, 32'(in_ready), 32'd1);
        chk("abort_busy", 21, 32'(busy), 32'd0);
        chk("abort_result", 21, result, 32'h0);
        chk("abort_flags", 21, 32'(flags), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_abort_out_valid", 21, 32'(out_valid), 32'd0);
        chk("post_abort_in_ready", 21, 32'(in_ready), 32'd1);

        // One more op after the abort to confirm the unit recovered.
        issue(22, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 5);
        drain();
        chk("queue_empty", 0, 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
